// File: rtl/bus_mmio_pkg.sv
// rtl/bus_mmio_pkg.sv - register offsets, STATUS layout and FSM encoding for the MMIO console
package bus_mmio_pkg;

  // Word offsets decoded from bus_addr[3:2]
  localparam logic [1:0] OFF_DATA   = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;

  // STATUS bit positions
  localparam int STAT_RX_NE      = 0;
  localparam int STAT_TX_FULL    = 1;
  localparam int STAT_RX_OVF     = 2;
  localparam int STAT_RX_CNT_LSB = 8;
  localparam int STAT_TX_CNT_LSB = 16;
  localparam int STAT_CNT_W      = 5;

  // Read data returned for a DATA read while RX is empty
  localparam logic [31:0] RX_EMPTY_WORD = 32'hFFFF_FFFF;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RESP    = 2'd1,
    ST_WAIT_TX = 2'd2
  } state_t;

  // Assemble the STATUS word; unlisted bits stay zero
  function automatic logic [31:0] build_status(
    input logic                  rx_ne,
    input logic                  tx_full,
    input logic                  rx_ovf,
    input logic [STAT_CNT_W-1:0] rx_cnt,
    input logic [STAT_CNT_W-1:0] tx_cnt
  );
    logic [31:0] s;
    s = '0;
    s[STAT_RX_NE]                         = rx_ne;
    s[STAT_TX_FULL]                       = tx_full;
    s[STAT_RX_OVF]                        = rx_ovf;
    s[STAT_RX_CNT_LSB +: STAT_CNT_W]      = rx_cnt;
    s[STAT_TX_CNT_LSB +: STAT_CNT_W]      = tx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// rtl/sync_fifo.sv - single-clock FIFO with same-cycle push/pop and occupancy count
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 8,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] head,
  output logic [CW-1:0]    count,
  output logic             full,
  output logic             empty
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    rd_ptr;
  logic [AW-1:0]    wr_ptr;
  logic             do_push;
  logic             do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_pop  = pop && !empty;
  // A full FIFO still takes a push when the head leaves in the same cycle
  assign do_push = push && (!full || do_pop);
  assign head    = mem[rd_ptr];

  // Storage array; no reset needed, occupancy is tracked by count
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // Pointers wrap naturally since DEPTH is a power of two
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + AW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/bus_mmio_console.sv
// rtl/bus_mmio_console.sv - memory-mapped byte console with TX/RX FIFOs and a status register
module bus_mmio_console
  import bus_mmio_pkg::*;
#(
  parameter logic [31:0] BASE  = 32'hFFFF_0000,
  parameter int          DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] bus_addr,
  input  logic [31:0] bus_wdata,
  input  logic        bus_rd,
  input  logic        bus_wr,
  output logic [31:0] bus_rdata,
  output logic        bus_ready,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid
);

  localparam int CW = $clog2(DEPTH + 1);

  state_t      state, state_next;
  logic [31:0] resp_data, resp_data_next;
  logic [7:0]  hold_byte, hold_byte_next;
  logic        overflow;
  logic        ovf_clear;
  logic        ovf_set;

  logic        hit, rd_req, wr_req;

  logic        tx_push, tx_pop, tx_full, tx_empty;
  logic [7:0]  tx_push_data;
  logic [CW-1:0] tx_count;

  logic        rx_pop, rx_full, rx_empty;
  logic [7:0]  rx_head;
  logic [CW-1:0] rx_count;

  logic        unused_bits;
  assign unused_bits = ^{bus_addr[1:0], bus_wdata[31:8]};

  assign hit    = (bus_addr[31:4] == BASE[31:4]);
  assign rd_req = hit && bus_rd;
  // A simultaneous read and write is treated as a read alone
  assign wr_req = hit && bus_wr && !bus_rd;

  assign tx_valid  = !tx_empty;
  assign tx_pop    = tx_valid && tx_ready;
  assign bus_ready = (state == ST_RESP);
  assign bus_rdata = bus_ready ? resp_data : '0;

  // A byte arriving on a full RX with no pop that cycle is lost
  assign ovf_set = rx_valid && rx_full && !rx_pop;

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_tx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (tx_push),
    .push_data (tx_push_data),
    .pop       (tx_pop),
    .head      (tx_data),
    .count     (tx_count),
    .full      (tx_full),
    .empty     (tx_empty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(DEPTH)) u_rx_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (rx_valid),
    .push_data (rx_data),
    .pop       (rx_pop),
    .head      (rx_head),
    .count     (rx_count),
    .full      (rx_full),
    .empty     (rx_empty)
  );

  // Access state, response word, stalled TX byte and sticky overflow
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= ST_IDLE;
      resp_data <= '0;
      hold_byte <= '0;
      overflow  <= 1'b0;
    end else begin
      state     <= state_next;
      resp_data <= resp_data_next;
      hold_byte <= hold_byte_next;
      if (ovf_set)        overflow <= 1'b1;
      else if (ovf_clear) overflow <= 1'b0;
    end
  end

  // Decode the access, drive FIFO strobes and pick the next state
  always_comb begin
    state_next     = state;
    resp_data_next = resp_data;
    hold_byte_next = hold_byte;
    tx_push        = 1'b0;
    tx_push_data   = bus_wdata[7:0];
    rx_pop         = 1'b0;
    ovf_clear      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (rd_req) begin
          state_next = ST_RESP;
          case (bus_addr[3:2])
            OFF_DATA: begin
              if (rx_empty) begin
                resp_data_next = RX_EMPTY_WORD;
              end else begin
                rx_pop         = 1'b1;
                resp_data_next = {24'b0, rx_head};
              end
            end
            OFF_STATUS: begin
              ovf_clear      = 1'b1;
              resp_data_next = build_status(!rx_empty, tx_full, overflow,
                                            STAT_CNT_W'(rx_count),
                                            STAT_CNT_W'(tx_count));
            end
            default: resp_data_next = '0;
          endcase
        end else if (wr_req) begin
          resp_data_next = '0;
          state_next     = ST_RESP;
          if (bus_addr[3:2] == OFF_DATA) begin
            if (tx_full) begin
              hold_byte_next = bus_wdata[7:0];
              state_next     = ST_WAIT_TX;
            end else begin
              tx_push = 1'b1;
            end
          end
        end
      end
      ST_RESP: state_next = ST_IDLE;
      ST_WAIT_TX: begin
        if (!tx_full) begin
          tx_push      = 1'b1;
          tx_push_data = hold_byte;
          state_next   = ST_RESP;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

endmodule

// File: tb/tb_bus_mmio_console.sv
// tb/tb_bus_mmio_console.sv - scoreboard bench for the MMIO console
module tb_bus_mmio_console;
  import bus_mmio_pkg::*;

  localparam logic [31:0] BASE  = 32'hFFFF_0000;
  localparam int          DEPTH = 8;

  logic        clk;
  logic        rst;
  logic [31:0] bus_addr;
  logic [31:0] bus_wdata;
  logic        bus_rd;
  logic        bus_wr;
  logic [31:0] bus_rdata;
  logic        bus_ready;
  logic [7:0]  tx_data;
  logic        tx_valid;
  logic        tx_ready;
  logic [7:0]  rx_data;
  logic        rx_valid;

  int          vec_count = 0;
  int          err_count = 0;
  logic [31:0] exp_q[$];
  logic [7:0]  rx_model[$];
  logic [7:0]  tx_model[$];
  int          w;

  bus_mmio_console #(.BASE(BASE), .DEPTH(DEPTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus_addr  (bus_addr),
    .bus_wdata (bus_wdata),
    .bus_rd    (bus_rd),
    .bus_wr    (bus_wr),
    .bus_rdata (bus_rdata),
    .bus_ready (bus_ready),
    .tx_data   (tx_data),
    .tx_valid  (tx_valid),
    .tx_ready  (tx_ready),
    .rx_data   (rx_data),
    .rx_valid  (rx_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_count++;
    if (got !== exp) begin
      err_count++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic release_bus();
    bus_rd    = 1'b0;
    bus_wr    = 1'b0;
    bus_addr  = '0;
    bus_wdata = '0;
  endtask

  task automatic issue(input logic rd, input logic wr, input logic [31:0] addr,
                       input logic [31:0] wdata, input logic has_resp, input logic [31:0] exp);
    if (has_resp) exp_q.push_back(exp);
    bus_rd    = rd;
    bus_wr    = wr;
    bus_addr  = addr;
    bus_wdata = wdata;
  endtask

  task automatic await(input string tag, input int budget, output int waited);
    logic        seen;
    logic [31:0] exp;
    seen   = 1'b0;
    waited = 0;
    while (!seen && waited < budget) begin
      @(negedge clk);
      waited++;
      if (bus_ready) seen = 1'b1;
    end
    if (seen) begin
      if (exp_q.size() == 0) begin
        check({tag, "_unexpected"}, 32'd1, 32'd0);
      end else begin
        exp = exp_q.pop_front();
        check(tag, bus_rdata, exp);
      end
    end else begin
      check({tag, "_timeout"}, 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end
    @(posedge clk);
    #1 release_bus();
  endtask

  task automatic access(input logic rd, input logic wr, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [31:0] exp, input string tag);
    int lat;
    issue(rd, wr, addr, wdata, 1'b1, exp);
    await(tag, 4, lat);
  endtask

  task automatic no_resp(input string tag, input int n);
    int hits;
    hits = 0;
    repeat (n) begin
      @(negedge clk);
      if (bus_ready) hits++;
    end
    check(tag, 32'(hits), 32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rst      = 1'b1;
    tx_ready = 1'b0;
    rx_valid = 1'b0;
    rx_data  = '0;
    release_bus();

    // reset state
    @(negedge clk);
    check("rst_ready", 32'(bus_ready), 32'd0);
    check("rst_rdata", bus_rdata, 32'd0);
    check("rst_tx_valid", 32'(tx_valid), 32'd0);
    @(posedge clk);
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

    // single TX write, completes the next cycle
    issue(1'b0, 1'b1, BASE, 32'hABCD_EF41, 1'b1, 32'd0);
    await("wr41", 4, w);
    check("wr41_latency", 32'(w), 32'd2);
    @(negedge clk);
    check("wr41_tx_valid", 32'(tx_valid), 32'd1);
    check("wr41_tx_data", 32'(tx_data), 32'h41);
    @(posedge clk);
    #1 tx_ready = 1'b1;
    @(posedge clk);
    #1 tx_ready = 1'b0;
    @(negedge clk);
    check("tx_drained", 32'(tx_valid), 32'd0);
    @(posedge clk);
    #1;

    // one RX byte, read it back, then STATUS shows RX empty
    rx_valid = 1'b1;
    rx_data  = 8'h5A;
    @(posedge clk);
    #1 rx_valid = 1'b0;
    access(1'b1, 1'b0, BASE, 32'd0, 32'h0000_005A, "rd5a");
    access(1'b1, 1'b0, BASE + 32'd4, 32'd0, 32'h0000_0000, "stat_after_rd");

    // empty read and address misses
    access(1'b1, 1'b0, BASE, 32'd0, RX_EMPTY_WORD, "rd_empty");
    issue(1'b1, 1'b0, 32'h1234_0000, 32'd0, 1'b0, 32'd0);
    no_resp("miss_rd", 4);
    @(posedge clk);
    #1 release_bus();
    issue(1'b0, 1'b1, BASE + 32'h10, 32'h77, 1'b0, 32'd0);
    no_resp("miss_wr", 4);
    @(posedge clk);
    #1 release_bus();

    // reserved slots, read-only STATUS, read-wins on rd+wr
    access(1'b1, 1'b0, BASE + 32'h8, 32'd0, 32'd0, "rd_rsvd");
    access(1'b0, 1'b1, BASE + 32'hC, 32'h55, 32'd0, "wr_rsvd");
    access(1'b0, 1'b1, BASE + 32'h4, 32'hFFFF_FFFF, 32'd0, "wr_status");
    access(1'b1, 1'b1, BASE, 32'h33, RX_EMPTY_WORD, "rdwr");
    access(1'b1, 1'b0, BASE + 32'd4, 32'd0, 32'd0, "stat_no_side_effect");

    // RX overflow and sticky-clear behaviour
    for (int i = 0; i < 9; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h20 + i);
      if (i < DEPTH) rx_model.push_back(8'(8'h20 + i));
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    access(1'b1, 1'b0, BASE + 32'd4, 32'd0, 32'h0000_0805, "stat_ovf");
    access(1'b1, 1'b0, BASE + 32'd4, 32'd0, 32'h0000_0801, "stat_ovf_clr");
    for (int i = 0; i < DEPTH; i++)
      access(1'b1, 1'b0, BASE, 32'd0, {24'b0, rx_model.pop_front()}, "rx_drain1");

    // full RX popped and pushed in the same cycle
    for (int i = 0; i < DEPTH; i++) begin
      rx_valid = 1'b1;
      rx_data  = 8'(8'h10 + i);
      rx_model.push_back(8'(8'h10 + i));
      @(posedge clk);
      #1;
    end
    rx_valid = 1'b0;
    issue(1'b1, 1'b0, BASE, 32'd0, 1'b1, {24'b0, rx_model.pop_front()});
    rx_valid = 1'b1;
    rx_data  = 8'h99;
    rx_model.push_back(8'h99);
    @(posedge clk);
    #1 rx_valid = 1'b0;
    await("rd_full_push", 4, w);
    access(1'b1, 1'b0, BASE + 32'd4, 32'd0, 32'h0000_0801, "stat_full_push");
    for (int i = 0; i < DEPTH; i++)
      access(1'b1, 1'b0, BASE, 32'd0, {24'b0, rx_model.pop_front()}, "rx_drain2");

    // TX backpressure: 9th write stalls until a slot opens
    for (int i = 0; i < DEPTH; i++) begin
      tx_model.push_back(8'(8'h60 + i));
      access(1'b0, 1'b1, BASE, 32'(8'h60 + i), 32'd0, "tx_fill");
    end
    access(1'b1, 1'b0, BASE + 32'd4, 32'd0, 32'h0008_0002, "stat_tx_full");
    issue(1'b0, 1'b1, BASE, 32'h68, 1'b1, 32'd0);
    no_resp("wait_tx_hold", 4);
    check("in_wait_tx", 32'(dut.state), 32'(ST_WAIT_TX));
    @(posedge clk);
    #1 tx_ready = 1'b1;
    void'(tx_model.pop_front());
    tx_model.push_back(8'h68);
    @(posedge clk);
    #1 tx_ready = 1'b0;
    await("wait_tx_done", 3, w);
    access(1'b1, 1'b0, BASE + 32'd4, 32'd0, 32'h0008_0002, "stat_tx_count8");
    tx_ready = 1'b1;
    for (int i = 0; i < DEPTH; i++) begin
      @(negedge clk);
      check("tx_drain_valid", 32'(tx_valid), 32'd1);
      check("tx_drain_data", 32'(tx_data), 32'(tx_model.pop_front()));
    end
    @(negedge clk);
    check("tx_drain_empty", 32'(tx_valid), 32'd0);
    @(posedge clk);
    #1 tx_ready = 1'b0;

    // reset while stalled in WAIT_TX
    for (int i = 0; i < DEPTH; i++)
      access(1'b0, 1'b1, BASE, 32'(8'h70 + i), 32'd0, "tx_fill2");
    issue(1'b0, 1'b1, BASE, 32'h78, 1'b0, 32'd0);
    no_resp("pre_rst", 3);
    #2 rst = 1'b1;
    release_bus();
    #1;
    check("rst_wait_ready", 32'(bus_ready), 32'd0);
    check("rst_wait_tx_valid", 32'(tx_valid), 32'd0);
    check("rst_wait_state", 32'(dut.state), 32'(ST_IDLE));
    @(posedge clk);
    #1 rst = 1'b0;
    no_resp("post_rst", 3);
    @(posedge clk);
    #1;
    access(1'b1, 1'b0, BASE + 32'd4, 32'd0, 32'd0, "stat_after_rst");

    check("sb_drain", 32'(exp_q.size()), 32'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vec_count, err_count);
    $finish;
  end

endmodule
